// File: rtl/sayeh_banked_regfile_pkg.sv
// Shared types and helpers for the SAYEH banked register file.
// Context-sequencer states, context op encoding and an address range test.
package sayeh_rf_pkg;

  typedef enum logic [1:0] {
    IDLE,
    COPY,
    DONE
  } ctx_state_t;

  localparam logic CTX_SAVE    = 1'b0;
  localparam logic CTX_RESTORE = 1'b1;

  // Guards non-power-of-2 depths, where an AW-bit index can exceed the array.
  function automatic logic in_range(input int unsigned idx, input int unsigned depth);
    return idx < depth;
  endfunction

endpackage

// File: rtl/sayeh_banked_regfile_if.sv
// Datapath/control-unit bus of the SAYEH banked register file.
// The master drives addresses, write data and ctx requests; the slave returns reads and ctx status.
interface sayeh_banked_regfile_if #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned LANE  = 8,
  parameter int unsigned DEPTH = 4
);
  localparam int unsigned NB = WIDTH / LANE;
  localparam int unsigned AW = $clog2(DEPTH);

  logic [AW-1:0]    wr_addr;
  logic [WIDTH-1:0] wr_data;
  logic [NB-1:0]    wr_be;
  logic [AW-1:0]    rd_addr_l;
  logic [AW-1:0]    rd_addr_r;
  logic [WIDTH-1:0] rd_data_l;
  logic [WIDTH-1:0] rd_data_r;
  logic             ctx_req;
  logic             ctx_op;
  logic             ctx_busy;
  logic             ctx_done;

  modport master (
    output wr_addr, wr_data, wr_be, rd_addr_l, rd_addr_r, ctx_req, ctx_op,
    input  rd_data_l, rd_data_r, ctx_busy, ctx_done
  );

  modport slave (
    input  wr_addr, wr_data, wr_be, rd_addr_l, rd_addr_r, ctx_req, ctx_op,
    output rd_data_l, rd_data_r, ctx_busy, ctx_done
  );

endinterface

// File: rtl/sayeh_banked_regfile_bank.sv
// One DEPTH x WIDTH register bank: byte-lane write port, two async read ports,
// and a full-width copy port (address, write enable, data, readout) used by the context sequencer.
module sayeh_rf_bank
  import sayeh_rf_pkg::*;
#(
  parameter  int unsigned WIDTH = 16,
  parameter  int unsigned LANE  = 8,
  parameter  int unsigned DEPTH = 4,
  localparam int unsigned NB    = WIDTH / LANE,
  localparam int unsigned AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [AW-1:0]    we_addr,
  input  logic [WIDTH-1:0] we_data,
  input  logic [NB-1:0]    we_be,
  input  logic             cp_we,
  input  logic [AW-1:0]    cp_addr,
  input  logic [WIDTH-1:0] cp_data,
  output logic [WIDTH-1:0] cp_q,
  input  logic [AW-1:0]    rd_addr_a,
  output logic [WIDTH-1:0] rd_data_a,
  input  logic [AW-1:0]    rd_addr_b,
  output logic [WIDTH-1:0] rd_data_b
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Copy writes outrank lane writes; the top level never issues both, but the bank stays well defined.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (cp_we) begin
      mem[cp_addr] <= cp_data;
    end else if (in_range(32'(we_addr), DEPTH)) begin
      for (int unsigned i = 0; i < NB; i++) begin
        if (we_be[i]) begin
          mem[we_addr][i*LANE +: LANE] <= we_data[i*LANE +: LANE];
        end
      end
    end
  end

  assign cp_q      = mem[cp_addr];
  assign rd_data_a = in_range(32'(rd_addr_a), DEPTH) ? mem[rd_addr_a] : '0;
  assign rd_data_b = in_range(32'(rd_addr_b), DEPTH) ? mem[rd_addr_b] : '0;

endmodule

// File: rtl/sayeh_banked_regfile.sv
// SAYEH register file: active bank with byte-lane writes and optional write-to-read bypass,
// plus a shadow bank filled/drained one register per cycle by the context sequencer.
module sayeh_banked_regfile
  import sayeh_rf_pkg::*;
#(
  parameter int unsigned WIDTH  = 16,
  parameter int unsigned LANE   = 8,
  parameter int unsigned DEPTH  = 4,
  parameter bit          BYPASS = 1'b1
) (
  input  logic                   clk,
  input  logic                   rst,
  sayeh_banked_regfile_if.slave  bus
);

  localparam int unsigned NB   = WIDTH / LANE;
  localparam int unsigned AW   = $clog2(DEPTH);
  localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

  ctx_state_t       state;
  logic [AW-1:0]    idx;
  logic             op;
  logic             busy_q;
  logic             done_q;

  logic             wr_ok;
  logic [NB-1:0]    act_be;
  logic             act_cp_we;
  logic             sh_cp_we;
  logic [WIDTH-1:0] act_rd_l;
  logic [WIDTH-1:0] act_rd_r;
  logic [WIDTH-1:0] act_cp_q;
  logic [WIDTH-1:0] sh_cp_q;
  logic [WIDTH-1:0] sh_unused_a;
  logic [WIDTH-1:0] sh_unused_b;
  logic [WIDTH-1:0] rd_l;
  logic [WIDTH-1:0] rd_r;

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      idx    <= '0;
      op     <= CTX_SAVE;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          done_q <= 1'b0;
          if (bus.ctx_req) begin
            state  <= COPY;
            op     <= bus.ctx_op;
            idx    <= '0;
            busy_q <= 1'b1;
          end
        end
        COPY: begin
          if (idx == LAST) begin
            state  <= DONE;
            idx    <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b1;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        DONE: begin
          state  <= IDLE;
          done_q <= 1'b0;
        end
        default: begin
          state  <= IDLE;
          idx    <= '0;
          busy_q <= 1'b0;
          done_q <= 1'b0;
        end
      endcase
    end
  end

  // A write in the ctx accept cycle lands before COPY starts, so a SAVE captures it.
  assign wr_ok     = (state != COPY) && !rst;
  assign act_be    = wr_ok ? bus.wr_be : '0;
  assign act_cp_we = (state == COPY) && (op == CTX_RESTORE);
  assign sh_cp_we  = (state == COPY) && (op == CTX_SAVE);

  sayeh_rf_bank #(
    .WIDTH (WIDTH),
    .LANE  (LANE),
    .DEPTH (DEPTH)
  ) u_active (
    .clk       (clk),
    .rst       (rst),
    .we_addr   (bus.wr_addr),
    .we_data   (bus.wr_data),
    .we_be     (act_be),
    .cp_we     (act_cp_we),
    .cp_addr   (idx),
    .cp_data   (sh_cp_q),
    .cp_q      (act_cp_q),
    .rd_addr_a (bus.rd_addr_l),
    .rd_data_a (act_rd_l),
    .rd_addr_b (bus.rd_addr_r),
    .rd_data_b (act_rd_r)
  );

  sayeh_rf_bank #(
    .WIDTH (WIDTH),
    .LANE  (LANE),
    .DEPTH (DEPTH)
  ) u_shadow (
    .clk       (clk),
    .rst       (rst),
    .we_addr   ('0),
    .we_data   ('0),
    .we_be     ('0),
    .cp_we     (sh_cp_we),
    .cp_addr   (idx),
    .cp_data   (act_cp_q),
    .cp_q      (sh_cp_q),
    .rd_addr_a (idx),
    .rd_data_a (sh_unused_a),
    .rd_addr_b (idx),
    .rd_data_b (sh_unused_b)
  );

  // Per-lane bypass; out-of-range write addresses are dropped, so they never forward.
  always_comb begin
    rd_l = act_rd_l;
    rd_r = act_rd_r;
    if (BYPASS && wr_ok && in_range(32'(bus.wr_addr), DEPTH)) begin
      for (int unsigned i = 0; i < NB; i++) begin
        if (bus.wr_be[i]) begin
          if (bus.wr_addr == bus.rd_addr_l) rd_l[i*LANE +: LANE] = bus.wr_data[i*LANE +: LANE];
          if (bus.wr_addr == bus.rd_addr_r) rd_r[i*LANE +: LANE] = bus.wr_data[i*LANE +: LANE];
        end
      end
    end
  end

  assign bus.rd_data_l = rd_l;
  assign bus.rd_data_r = rd_r;
  assign bus.ctx_busy  = busy_q;
  assign bus.ctx_done  = done_q;

endmodule
